// File: rtl/layer1_maxpool_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | layer1_maxpool_pkg : constants and state encoding shared by layers  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package layer1_maxpool_pkg;

  localparam int DW      = 20;
  localparam int IMG_W   = 64;
  localparam int IMG_H   = 64;
  localparam int POOL_W  = IMG_W / 2;
  localparam int POOL_H  = IMG_H / 2;
  localparam int POOL_N  = POOL_W * POOL_H;
  localparam int POOL_AW = $clog2(POOL_N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pool_linebuf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pool_linebuf : partial row-pair maxima, 1 write / 1 comb read port  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module pool_linebuf #(
  parameter int DEPTH = 32,
  parameter int DW    = 20
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DW-1:0]            i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DW-1:0]            o_rdata
);

  // Not reset: every entry is written on an even row before the odd row reads it.
  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/layer1_maxpool.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | layer1_maxpool : 2x2 stride-2 max-pool, emits addressed pooled map  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module layer1_maxpool #(
  parameter int IMG_W = layer1_maxpool_pkg::IMG_W,
  parameter int IMG_H = layer1_maxpool_pkg::IMG_H,
  parameter int DW    = layer1_maxpool_pkg::DW
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [DW-1:0]                            in_data,
  input  logic                                     kernel_sel,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [DW-1:0]                            out_data,
  output logic [$clog2((IMG_W/2)*(IMG_H/2))-1:0]   out_addr,
  output logic                                     out_kernel,
  output logic                                     frame_done
);

  import layer1_maxpool_pkg::*;

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int AW = $clog2((IMG_W/2)*(IMG_H/2));

  localparam logic [AW-1:0] C_LAST_ADDR = AW'((IMG_W/2)*(IMG_H/2) - 1);
  localparam logic [CW-1:0] C_LAST_COL  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] C_LAST_ROW  = RW'(IMG_H - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [DW-1:0] r_hold;
  logic [DW-1:0] r_out_data;
  logic [AW-1:0] r_out_addr;
  logic          r_out_valid;
  logic          r_out_kernel;

  logic          w_accept;
  logic          w_handoff;
  logic          w_lb_we;
  logic          w_emit;
  logic [DW-1:0] w_lb_rdata;
  logic [DW-1:0] w_pair_max;
  logic [DW-1:0] w_win_max;
  logic [AW-1:0] w_win_addr;

  assign in_ready   = (r_state != DONE) && !(r_out_valid && !out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_handoff  = r_out_valid && out_ready;
  assign w_lb_we    = w_accept && !r_row[0] && r_col[0];
  assign w_emit     = w_accept &&  r_row[0] && r_col[0];

  assign w_pair_max = (in_data > r_hold) ? in_data : r_hold;
  assign w_win_max  = (w_lb_rdata > w_pair_max) ? w_lb_rdata : w_pair_max;
  assign w_win_addr = AW'(r_row >> 1) * AW'(IMG_W / 2) + AW'(r_col >> 1);

  pool_linebuf #(
    .DEPTH (IMG_W / 2),
    .DW    (DW)
  ) u_linebuf (
    .clk     (clk),
    .i_we    (w_lb_we),
    .i_waddr (r_col[CW-1:1]),
    .i_wdata (w_pair_max),
    .i_raddr (r_col[CW-1:1]),
    .o_rdata (w_lb_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = RUN;
      RUN:     if (w_handoff && (r_out_addr == C_LAST_ADDR)) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Kernel is latched on pixel (0,0) so a frame starting in the last-handoff cycle still tags correctly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col        <= '0;
      r_row        <= '0;
      r_hold       <= '0;
      r_out_kernel <= 1'b0;
    end else if (w_accept) begin
      if (!r_col[0]) r_hold <= in_data;
      if ((r_col == '0) && (r_row == '0)) r_out_kernel <= kernel_sel;
      if (r_col == C_LAST_COL) begin
        r_col <= '0;
        r_row <= (r_row == C_LAST_ROW) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
    end else if (w_emit) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_win_max;
      r_out_addr  <= w_win_addr;
    end else if (w_handoff) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_addr   = r_out_addr;
  assign out_kernel = r_out_kernel;
  assign frame_done = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_layer1_maxpool.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_layer1_maxpool : random/directed frames vs. window-max model     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_layer1_maxpool;

  localparam int W  = 64;
  localparam int H  = 64;
  localparam int PW = W / 2;
  localparam int NP = (W / 2) * (H / 2);

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_data;
  logic        kernel_sel;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_data;
  logic [9:0]  out_addr;
  logic        out_kernel;
  logic        frame_done;

  always #5 clk = ~clk;

  layer1_maxpool dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .kernel_sel (kernel_sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .out_kernel (out_kernel),
    .frame_done (frame_done)
  );

  typedef struct { logic [19:0] d; int r; int c; logic k; } pix_t;
  typedef struct { logic [19:0] d; int a; logic k; } res_t;

  pix_t        pix_q[$];
  res_t        exp_q[$];
  logic [19:0] img [H][W];
  int          total = 0;
  int          bad   = 0;
  int          frames_seen = 0;
  bit          mv;           // model: a pooled result is pending this cycle
  bit          fd;           // model: this is the cycle after the final handoff
  bit          stall_armed;
  int          stall_left;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: ramp, 1: sparse directed patterns, 2: random
  function automatic void load_frame(int mode, logic k);
    logic [19:0] m;
    pix_t p;
    res_t e;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (mode)
          0:       img[r][c] = 20'(r * W + c);
          1:       img[r][c] = 20'h0;
          default: img[r][c] = 20'($urandom);
        endcase
    if (mode == 1) begin
      img[2][4]   = 20'h0FFFF;
      img[4][0]   = 20'h7FFFF;
      img[5][1]   = 20'h80000;
      img[6][2]   = 20'h80000;
      img[7][3]   = 20'h7FFFF;
      img[63][63] = 20'hFFFFF;
    end
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        p.d = img[r][c]; p.r = r; p.c = c; p.k = k;
        pix_q.push_back(p);
      end
    for (int pr = 0; pr < H / 2; pr++)
      for (int pc = 0; pc < PW; pc++) begin
        m = 20'h0;
        for (int dr = 0; dr < 2; dr++)
          for (int dc = 0; dc < 2; dc++)
            if (img[2*pr+dr][2*pc+dc] > m) m = img[2*pr+dr][2*pc+dc];
        e.d = m; e.a = pr * PW + pc; e.k = k;
        exp_q.push_back(e);
      end
  endfunction

  // Entered and left at posedge+1; inputs change there, outputs sampled at negedge.
  task automatic drive(int gap_pct, int stop_after, int stall_addr);
    int cyc = 0;
    int acc = 0;
    bit rdy_exp;
    bit acc_now;
    forever begin
      if (stop_after >= 0 && acc >= stop_after) break;
      if (pix_q.size() == 0 && exp_q.size() == 0 && !mv && !fd) break;
      if (cyc >= 20000) begin
        check("timeout_pending", pix_q.size() + exp_q.size(), 0);
        break;
      end
      in_valid = (pix_q.size() > 0) && ($urandom_range(99) >= gap_pct);
      if (pix_q.size() > 0) begin
        in_data    = pix_q[0].d;
        kernel_sel = pix_q[0].k;
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else if (stall_armed && mv && exp_q.size() > 0 && exp_q[0].a == stall_addr) begin
        stall_armed = 1'b0;
        out_ready   = 1'b0;
        stall_left  = 4;
      end else begin
        out_ready = 1'b1;
      end

      @(negedge clk);
      rdy_exp = !fd && !(mv && !out_ready);
      check("out_valid", out_valid, mv);
      check("frame_done", frame_done, fd);
      check("in_ready", in_ready, rdy_exp);
      if (frame_done) frames_seen++;
      if (mv && exp_q.size() > 0) begin
        check("out_data", out_data, exp_q[0].d);
        check("out_addr", out_addr, exp_q[0].a);
        check("out_kernel", out_kernel, exp_q[0].k);
      end

      acc_now = in_valid && rdy_exp;
      fd = 1'b0;
      if (mv && out_ready && exp_q.size() > 0) begin
        if (exp_q[0].a == NP - 1) fd = 1'b1;
        void'(exp_q.pop_front());
      end
      mv = mv && !out_ready;
      if (acc_now && pix_q.size() > 0) begin
        if (pix_q[0].r % 2 == 1 && pix_q[0].c % 2 == 1) mv = 1'b1;
        void'(pix_q.pop_front());
        acc++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    int f0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; kernel_sel = 1'b0; out_ready = 1'b1;
    mv = 1'b0; fd = 1'b0; stall_armed = 1'b0; stall_left = 0;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_out_kernel", out_kernel, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1 rst = 1'b1;

    // ramp frame, no gaps
    load_frame(0, 1'b0);
    drive(0, -1, -1);
    check("ramp_frames", frames_seen, 1);

    // directed window patterns incl. unsigned 0x80000 vs 0x7FFFF
    load_frame(1, 1'b1);
    drive(0, -1, -1);

    // ramp with 30% input gaps and a 5-cycle output stall on addr 33
    load_frame(0, 1'b0);
    stall_armed = 1'b1;
    drive(30, -1, 33);
    check("stall_hit", stall_armed, 0);

    // random data with gaps
    load_frame(2, 1'b1);
    drive(10, -1, -1);

    // back-to-back frames, kernel 0 then 1
    f0 = frames_seen;
    load_frame(0, 1'b0);
    load_frame(0, 1'b1);
    drive(0, -1, -1);
    check("b2b_frames", frames_seen - f0, 2);

    // reset mid-frame after 1500 pixels, then a full kernel-1 frame
    load_frame(0, 1'b1);
    drive(0, 1500, -1);
    in_valid = 1'b0;
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_out_data", out_data, 0);
      check("mid_rst_out_addr", out_addr, 0);
      check("mid_rst_out_kernel", out_kernel, 0);
      check("mid_rst_frame_done", frame_done, 0);
    end
    pix_q.delete();
    exp_q.delete();
    mv = 1'b0; fd = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    load_frame(0, 1'b1);
    drive(0, -1, -1);
    check("post_rst_kernel", out_kernel, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
